z80_io_decoder: RTL and testbench

- Synthesizable Z80 bus slave front end; sits directly downstream of the Z80 bus (CPU or bench bus model) inside the CPLD.
- Synchronizes the asynchronous /MREQ, /IORQ, /RD and /WR strobes into the `clk` domain and decodes port addresses.
- Produces single-cycle register write/read strobes for the register bank behind it.
- Drives read data back onto the Z80 data bus.

---
 rtl/z80_io_pkg.sv | 18 +
 rtl/z80_strobe_sync.sv | 26 ++
 rtl/z80_io_decoder.sv | 166 ++++++++++++++++
 tb/tb_z80_io_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_io_pkg.sv
// Shared types and defaults for the Z80 bus slave front end.
// Holds the decoder FSM state encoding and the address-match defaults.
// No logic; imported by the decoder and its synchronizer.
package z80_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_PULSE = 3'd1,
    ST_RD_PULSE = 3'd2,
    ST_RD_LOAD  = 3'd3,
    ST_WAIT_END = 3'd4
  } state_t;

  localparam logic [7:0] IO_MATCH_DEF  = 8'hAB;
  localparam logic [5:0] MEM_MATCH_DEF = 6'h3F;
  localparam int         REG_BITS_DEF  = 3;

endpackage

// File: rtl/z80_strobe_sync.sv
// Purpose: multi-flop synchronizer for the 4-bit Z80 strobe vector {mreq,iorq,rd,wr}.
// Latency: SYNC_STAGES clk cycles from raw input to synchronized output.
// Backpressure: none; free-running, resets to all-ones (all strobes inactive).
module z80_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] strb_raw,
  output logic [3:0] strb_sync
);

  logic [SYNC_STAGES*4-1:0] chain;

  // Shift the raw strobes through SYNC_STAGES flops; reset to inactive (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES*4-5:0], strb_raw};
    end
  end

  assign strb_sync = chain[SYNC_STAGES*4-1 -: 4];

endmodule

// File: rtl/z80_io_decoder.sv
// Purpose: Z80 bus slave decode; turns synchronized I/O (and optional memory-window) cycles into reg strobes.
// Latency: strobe SYNC_STAGES+1 clks after /RD or /WR falls; read data driven SYNC_STAGES+3 clks after /RD falls.
// Backpressure: none; one strobe per bus cycle, bus must honour minimum strobe widths. Option macro: Z80_MEMWIN_EN.
module z80_io_decoder
  import z80_io_pkg::*;
#(
  parameter logic [7:0] IO_MATCH    = IO_MATCH_DEF,
  parameter int         REG_BITS    = REG_BITS_DEF,
`ifdef Z80_MEMWIN_EN
  parameter logic [5:0] MEM_MATCH   = MEM_MATCH_DEF,
`endif
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                z80_mreq_n,
  input  logic                z80_iorq_n,
  input  logic                z80_rd_n,
  input  logic                z80_wr_n,
  input  logic [15:0]         z80_a,
  input  logic [7:0]          z80_d_in,
  output logic [7:0]          z80_d_out,
  output logic                z80_d_oe,
  output logic                wr_stb,
  output logic                rd_stb,
  output logic [REG_BITS-1:0] reg_addr,
  output logic [7:0]          wr_data,
`ifdef Z80_MEMWIN_EN
  output logic                mem_sel,
`endif
  input  logic [7:0]          rd_data
);

  localparam int HW = $clog2(SYNC_STAGES + 1);

  logic [3:0]    strb_sync;
  logic          s_mreq_n, s_iorq_n, s_rd_n, s_wr_n;
  logic          claim_io, claim_mem, claim;
  logic          latch_addr, latch_wdat;
  logic          oe_off;
  logic [HW-1:0] hold;
  state_t        state, state_nxt;

  // Address bits outside the decode are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^z80_a;

  z80_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .strb_raw ({z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n}),
    .strb_sync(strb_sync)
  );

  assign {s_mreq_n, s_iorq_n, s_rd_n, s_wr_n} = strb_sync;

  assign claim_io = !s_iorq_n && s_mreq_n && (z80_a[7:0] == IO_MATCH);
`ifdef Z80_MEMWIN_EN
  assign claim_mem = !s_mreq_n && s_iorq_n && (z80_a[15:10] == MEM_MATCH);
  // Read data stays on the bus only while /RD and the cycle's own select strobe are low.
  assign oe_off    = z80_rd_n || (mem_sel ? z80_mreq_n : z80_iorq_n);
`else
  assign claim_mem = 1'b0;
  assign oe_off    = z80_rd_n || z80_iorq_n;
`endif
  assign claim = claim_io || claim_mem;

  // Next-state decode: one pass through a strobe state per bus cycle, then park in WAIT_END.
  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    latch_wdat = 1'b0;
    case (state)
      ST_IDLE: begin
        if (claim) begin
          if (!s_wr_n && s_rd_n) begin
            state_nxt  = ST_WR_PULSE;
            latch_addr = 1'b1;
            latch_wdat = 1'b1;
          end else if (!s_rd_n && s_wr_n) begin
            state_nxt  = ST_RD_PULSE;
            latch_addr = 1'b1;
          end else if (!s_rd_n && !s_wr_n) begin
            state_nxt  = ST_WAIT_END;
          end
        end
      end
      ST_WR_PULSE: state_nxt = ST_WAIT_END;
      ST_RD_PULSE: state_nxt = ST_RD_LOAD;
      ST_RD_LOAD:  state_nxt = ST_WAIT_END;
      ST_WAIT_END: begin
        // hold keeps us here until the synchronizer has refilled after reset,
        // so a cycle already in flight at reset release is never decoded.
        if (hold == '0 && s_iorq_n && s_rd_n && s_wr_n) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_WAIT_END;
    endcase
  end

  // State register plus post-reset settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_END;
      hold  <= HW'(SYNC_STAGES);
    end else begin
      state <= state_nxt;
      if (hold != '0) begin
        hold <= hold - HW'(1);
      end
    end
  end

  // Registered single-cycle strobes, aligned with the pulse states.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
    end else begin
      wr_stb <= (state_nxt == ST_WR_PULSE);
      rd_stb <= (state_nxt == ST_RD_PULSE);
    end
  end

  // Capture register index (and write data) at decode time while the bus is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_addr <= '0;
      wr_data  <= '0;
`ifdef Z80_MEMWIN_EN
      mem_sel  <= 1'b0;
`endif
    end else begin
      if (latch_addr) begin
        reg_addr <= claim_mem ? z80_a[REG_BITS-1:0] : z80_a[8 +: REG_BITS];
`ifdef Z80_MEMWIN_EN
        mem_sel  <= claim_mem;
`endif
      end
      if (latch_wdat) begin
        wr_data <= z80_d_in;
      end
    end
  end

  // Load bank read data one cycle after rd_stb; enable drops on the first raw release.
  always_ff @(posedge clk) begin
    if (rst) begin
      z80_d_out <= '0;
      z80_d_oe  <= 1'b0;
    end else begin
      if (state == ST_RD_LOAD) begin
        z80_d_out <= rd_data;
      end
      if (oe_off) begin
        z80_d_oe <= 1'b0;
      end else if (state_nxt == ST_RD_LOAD) begin
        z80_d_oe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z80_io_decoder.sv
// Bench for z80_io_decoder: directed bus cycles plus randomized cycles vs a behavioural model.
// Bus model drives/samples 1ns after the falling clk edge.
// Optional memory window exercised when Z80_MEMWIN_EN is defined.
module tb_z80_io_decoder;

  localparam int S   = 2;
  localparam int LOW = S + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        z80_mreq_n = 1'b1, z80_iorq_n = 1'b1, z80_rd_n = 1'b1, z80_wr_n = 1'b1;
  logic [15:0] z80_a = '0;
  logic [7:0]  z80_d_in = '0;
  logic [7:0]  z80_d_out;
  logic        z80_d_oe, wr_stb, rd_stb;
  logic [2:0]  reg_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data = '0;
`ifdef Z80_MEMWIN_EN
  logic        mem_sel;
`endif

  always #5 clk = ~clk;

  z80_io_decoder dut (
    .clk(clk), .rst(rst),
    .z80_mreq_n(z80_mreq_n), .z80_iorq_n(z80_iorq_n),
    .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_a(z80_a), .z80_d_in(z80_d_in),
    .z80_d_out(z80_d_out), .z80_d_oe(z80_d_oe),
    .wr_stb(wr_stb), .rd_stb(rd_stb),
    .reg_addr(reg_addr), .wr_data(wr_data),
`ifdef Z80_MEMWIN_EN
    .mem_sel(mem_sel),
`endif
    .rd_data(rd_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // Event monitor: counts strobes and snapshots the register-side outputs at each strobe.
  int         wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
  logic [2:0] wr_addr_seen = '0, rd_addr_seen = '0;
  logic [7:0] wr_data_seen = '0;
  logic       sel_seen = 1'b0;
  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      wr_addr_seen = reg_addr;
      wr_data_seen = wr_data;
`ifdef Z80_MEMWIN_EN
      sel_seen = mem_sel;
`endif
    end
    if (rd_stb) begin
      rd_cnt++;
      rd_addr_seen = reg_addr;
`ifdef Z80_MEMWIN_EN
      sel_seen = mem_sel;
`endif
    end
    if (z80_d_oe) oe_cnt++;
  end

  logic [7:0] dsamp;
  logic       oe_end, oe_after;
  int         w0, r0, o0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
  endtask

  // One complete bus cycle: strobes low for LOW clks, bus samples data, then one released clk.
  task automatic bus_cycle(input logic is_mem, input logic is_wr, input logic is_rd,
                           input logic [15:0] a, input logic [7:0] d, input logic [7:0] rdv);
    z80_a = a; z80_d_in = d; rd_data = rdv;
    z80_mreq_n = !is_mem; z80_iorq_n = is_mem;
    z80_rd_n = !is_rd; z80_wr_n = !is_wr;
    repeat (LOW) tick();
    dsamp = z80_d_out;
    oe_end = z80_d_oe;
    z80_mreq_n = 1'b1; z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1;
    tick();
    oe_after = z80_d_oe;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    vectors++;
    if ({z80_d_out, z80_d_oe, wr_stb, rd_stb, reg_addr, wr_data} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got d_out=%h oe=%b wr=%b rd=%b addr=%0d wdat=%h, need all zero",
               z80_d_out, z80_d_oe, wr_stb, rd_stb, reg_addr, wr_data);
    end
`ifdef Z80_MEMWIN_EN
    vectors++;
    if (mem_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mem_sel: got %b need 0", mem_sel);
    end
`endif
    rst = 1'b0;
    idle(S + 3);
  endtask

  task automatic test_io_write();
    snap();
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h03AB, 8'h5A, 8'h00);
    idle(2);
    vectors++;
    if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin
      miscompares++;
      $display("FAIL io_write_count: got wr=%0d rd=%0d need wr=1 rd=0", wr_cnt - w0, rd_cnt - r0);
    end
    vectors++;
    if (wr_addr_seen !== 3'd3 || wr_data_seen !== 8'h5A) begin
      miscompares++;
      $display("FAIL io_write_latch: got addr=%0d data=%h need addr=3 data=5a", wr_addr_seen, wr_data_seen);
    end
    vectors++;
    if (oe_cnt - o0 !== 0) begin
      miscompares++;
      $display("FAIL io_write_oe: d_oe high %0d cycles, need 0", oe_cnt - o0);
    end
  endtask

  task automatic test_io_read();
    snap();
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h05AB, 8'h00, 8'hC3);
    vectors++;
    if (oe_after !== 1'b0) begin
      miscompares++;
      $display("FAIL io_read_oe_off: got %b one clk after /RD release, need 0", oe_after);
    end
    idle(2);
    vectors++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0 || rd_addr_seen !== 3'd5) begin
      miscompares++;
      $display("FAIL io_read_strobe: got rd=%0d wr=%0d addr=%0d need rd=1 wr=0 addr=5",
               rd_cnt - r0, wr_cnt - w0, rd_addr_seen);
    end
    vectors++;
    if (oe_end !== 1'b1 || dsamp !== 8'hC3) begin
      miscompares++;
      $display("FAIL io_read_data: got oe=%b data=%h need oe=1 data=c3", oe_end, dsamp);
    end
  endtask

  task automatic test_unclaimed();
    snap();
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h03AC, 8'h77, 8'h00);
    idle(2);
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h05AA, 8'h00, 8'h99);
    idle(2);
    vectors++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || oe_cnt - o0 !== 0) begin
      miscompares++;
      $display("FAIL unclaimed: got wr=%0d rd=%0d oe_cycles=%0d need all 0",
               wr_cnt - w0, rd_cnt - r0, oe_cnt - o0);
    end
  endtask

  task automatic test_mem_window();
    snap();
    bus_cycle(1'b1, 1'b1, 1'b0, 16'h03AB, 8'h44, 8'h00);
    idle(2);
    vectors++;
    if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin
      miscompares++;
      $display("FAIL mem_write_ignored: got wr=%0d rd=%0d need 0", wr_cnt - w0, rd_cnt - r0);
    end
`ifdef Z80_MEMWIN_EN
    snap();
    bus_cycle(1'b1, 1'b1, 1'b0, 16'hFC07, 8'h11, 8'h00);
    idle(2);
    vectors++;
    if (wr_cnt - w0 !== 1 || wr_addr_seen !== 3'd7 || wr_data_seen !== 8'h11 || sel_seen !== 1'b1) begin
      miscompares++;
      $display("FAIL mem_window_write: got wr=%0d addr=%0d data=%h sel=%b need 1/7/11/1",
               wr_cnt - w0, wr_addr_seen, wr_data_seen, sel_seen);
    end
`endif
  endtask

  task automatic test_reset_mid_cycle();
    snap();
    z80_a = 16'h01AB; z80_d_in = 8'hEE;
    z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(6);
    z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
    idle(S + 3);
    vectors++;
    if (wr_cnt - w0 !== 0 || oe_cnt - o0 !== 0) begin
      miscompares++;
      $display("FAIL reset_abort: got wr=%0d oe_cycles=%0d need 0", wr_cnt - w0, oe_cnt - o0);
    end
    snap();
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h02AB, 8'h22, 8'h00);
    idle(2);
    vectors++;
    if (wr_cnt - w0 !== 1 || wr_addr_seen !== 3'd2 || wr_data_seen !== 8'h22) begin
      miscompares++;
      $display("FAIL after_reset_write: got wr=%0d addr=%0d data=%h need 1/2/22",
               wr_cnt - w0, wr_addr_seen, wr_data_seen);
    end
  endtask

  task automatic test_back_to_back();
    snap();
    bus_cycle(1'b0, 1'b1, 1'b0, 16'h00AB, 8'hFF, 8'h00);
    bus_cycle(1'b0, 1'b0, 1'b1, 16'h00AB, 8'h00, 8'h3C);
    idle(3);
    vectors++;
    if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL back_to_back_count: got wr=%0d rd=%0d need 1/1", wr_cnt - w0, rd_cnt - r0);
    end
    vectors++;
    if (wr_data_seen !== 8'hFF || dsamp !== 8'h3C || oe_after !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_data: got wdat=%h rdat=%h oe_after=%b need ff/3c/0",
               wr_data_seen, dsamp, oe_after);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        is_mem, is_wr, is_rd, c_io, c_mem, claimed;
      logic [15:0] a;
      logic [7:0]  d, rdv;
      int          kind, exp_reg, exp_wr, exp_rd;
      kind   = int'($urandom_range(0, 4));
      is_mem = (kind == 2 || kind == 3);
      is_wr  = (kind == 0 || kind == 2 || kind == 4);
      is_rd  = (kind == 1 || kind == 3 || kind == 4);
      a      = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[7:0] = 8'hAB;
      if ($urandom_range(0, 2) == 0) a[15:10] = 6'h3F;
      d   = 8'($urandom);
      rdv = 8'($urandom);
      // Reference decode from the bus rules.
      c_io = !is_mem && (a % 256 == 16'd171);
`ifdef Z80_MEMWIN_EN
      c_mem = is_mem && (a / 1024 == 16'd63);
`else
      c_mem = 1'b0;
`endif
      claimed = c_io || c_mem;
      exp_reg = c_mem ? int'(a % 8) : int'((a / 256) % 8);
      exp_wr  = (claimed && is_wr && !is_rd) ? 1 : 0;
      exp_rd  = (claimed && is_rd && !is_wr) ? 1 : 0;
      snap();
      bus_cycle(is_mem, is_wr, is_rd, a, d, rdv);
      idle(2);
      vectors++;
      if (wr_cnt - w0 !== exp_wr || rd_cnt - r0 !== exp_rd) begin
        miscompares++;
        $display("FAIL rnd_count[%0d]: a=%h kind=%0d got wr=%0d rd=%0d need wr=%0d rd=%0d",
                 n, a, kind, wr_cnt - w0, rd_cnt - r0, exp_wr, exp_rd);
      end
      if (exp_wr == 1) begin
        vectors++;
        if (int'(wr_addr_seen) != exp_reg || wr_data_seen !== d || sel_seen !== c_mem) begin
          miscompares++;
          $display("FAIL rnd_write[%0d]: a=%h got addr=%0d data=%h sel=%b need %0d/%h/%b",
                   n, a, wr_addr_seen, wr_data_seen, sel_seen, exp_reg, d, c_mem);
        end
      end
      if (exp_rd == 1) begin
        vectors++;
        if (int'(rd_addr_seen) != exp_reg || dsamp !== rdv || oe_end !== 1'b1 || sel_seen !== c_mem) begin
          miscompares++;
          $display("FAIL rnd_read[%0d]: a=%h got addr=%0d data=%h oe=%b sel=%b need %0d/%h/1/%b",
                   n, a, rd_addr_seen, dsamp, oe_end, sel_seen, exp_reg, rdv, c_mem);
        end
      end else begin
        vectors++;
        if (oe_cnt - o0 !== 0) begin
          miscompares++;
          $display("FAIL rnd_oe[%0d]: a=%h kind=%0d d_oe high %0d cycles, need 0", n, a, kind, oe_cnt - o0);
        end
      end
      vectors++;
      if (oe_after !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_oe_off[%0d]: got %b after release, need 0", n, oe_after);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_io_write();
    test_io_read();
    test_unclaimed();
    test_mem_window();
    test_reset_mid_cycle();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
